corr_master: RTL and testbench
==============================

CORR_MASTER -- requirements
Module: corr_master

Interface
REQ-001 SHALL have parameter: POLL_LIMIT, default 255, maximum consecutive ack polls before timeout (used only with CORR_MASTER_TIMEOUT_EN).
REQ-002 SHALL have port: clk  in  1  single clock for all logic.
REQ-003 SHALL have port: reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: ld_we  in  1  host load strobe into the operand register file.
REQ-005 SHALL have port: ld_addr  in  4  operand word index; 0-3 template words, 4-8 signal words.
REQ-006 SHALL have port: ld_data  in  32  operand word; four signed bytes, byte 0 in [7:0].
REQ-007 SHALL have port: start  in  1  single-cycle request to run one correlation.
REQ-008 SHALL have port: busy  out  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port: done  out  1  one-cycle pulse on completion.
REQ-010 SHALL have port: err  out  1  sticky timeout flag for the last run.
REQ-011 SHALL have port: res_sel  in  3  result index 0-4.
REQ-012 SHALL have port: res_data  out  32  combinational result register selected by res_sel; 0 when res_sel > 4.
REQ-013 SHALL have ports: avm_address out 8; avm_read out 1; avm_write out 1; avm_writedata out 32; avm_readdata in 32; avm_waitrequest in 1 -- the Avalon-MM master driving the correlator slave.

Function
REQ-014 SHALL hold 9 operand words, written on ld_we while not busy; ld_addr > 8 is ignored; ld_we while busy is ignored.
REQ-015 SHALL accept start only in IDLE; start while busy is ignored.
REQ-016 SHALL use the same operand for a simultaneous ld_we and start in IDLE as it would for a load completed in an earlier cycle.
REQ-017 SHALL run states IDLE -> WR_DATA -> WR_SYNC1 -> POLL -> RD_RES -> WR_SYNC0 -> DONE -> IDLE.
REQ-018 WR_DATA SHALL issue 9 writes: avm_address = word index (0x0-0x8), avm_writedata = operand word, in index order.
REQ-019 WR_SYNC1 SHALL write 0x00000001 to address 0xA.
REQ-020 POLL SHALL read address 0xB and leave POLL when readdata[0] = 1; otherwise it re-issues the read next cycle.
REQ-021 RD_RES SHALL read addresses 0x10-0x14 into result registers 0-4.
REQ-022 WR_SYNC0 SHALL write 0x00000000 to address 0xA.
REQ-023 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-024 Bus transfer rules:
- Each transfer SHALL hold address, data and strobe stable while avm_waitrequest = 1.
- A transfer completes in a cycle with avm_waitrequest = 0.
- readdata SHALL be sampled in that same cycle (zero read latency).
REQ-025 SHALL never assert avm_read and avm_write together; both SHALL be 0 in IDLE and DONE.
REQ-026 SHALL issue the first transfer the cycle after start is sampled.
REQ-027 With waitrequest held 0 and ack returned on the 2nd poll, done SHALL pulse exactly 19 cycles after the start cycle.
REQ-028 Result registers SHALL persist until overwritten by a later run; err SHALL clear on an accepted start.

Reset
REQ-029 reset_n low SHALL immediately force, regardless of state, including mid-transfer:
- state IDLE;
- busy, done, err, avm_read, avm_write = 0;
- avm_address, avm_writedata = 0;
- all operand and result registers = 0.
REQ-030 The first start SHALL be accepted on the first clock edge after reset_n rises.

Configuration
REQ-031 With CORR_MASTER_TIMEOUT_EN defined, the poll timeout SHALL be active:
- a poll counter SHALL count completed POLL reads;
- if POLL_LIMIT reads return ack = 0, SHALL set err, skip RD_RES, perform WR_SYNC0, then DONE.
REQ-032 Without CORR_MASTER_TIMEOUT_EN, POLL SHALL wait indefinitely, err SHALL be constant 0, and no poll counter SHALL exist.

Verification
REQ-033 Load template bytes all 1 and signal bytes 1..20, start, waitrequest 0 -> res 0-4 = 136, 152, 168, 184, 200; done at start+19.
REQ-034 Assert waitrequest for 3 cycles on write 4 and on read 0x12 -> signals stay stable while stalled; results unchanged from REQ-033; done at start+25.
REQ-035 Hold ack 0 with timeout enabled and POLL_LIMIT = 4 -> exactly 4 polls, then write 0 to 0xA, err = 1, done pulses, no reads of 0x10-0x14.
REQ-036 Pulse start and ld_we during busy -> no restart, no operand change, exactly one done.
REQ-037 Drop reset_n during RD_RES -> bus strobes 0 in the same cycle, results 0; a fresh run afterwards completes normally.
REQ-038 Template bytes -128, signal bytes -128 -> res0 = 262144 (signed products, 32-bit accumulation).

Source files
------------

// File: rtl/corr_master.sv
// corr_master: Avalon-MM master that loads a correlator slave, polls for completion and collects five lag results.
// Build option: define CORR_MASTER_TIMEOUT_EN to bound the ack poll to POLL_LIMIT reads and drive err.
module corr_master #(
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_we,
  input  logic [3:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [2:0]  res_sel,
  output logic [31:0] res_data,
  output logic [7:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DATA, S_WR_SYNC1, S_POLL, S_RD_RES, S_WR_SYNC0, S_DONE
  } state_t;

  localparam logic [7:0] ADDR_SYNC = 8'h0A;
  localparam logic [7:0] ADDR_ACK  = 8'h0B;
  localparam logic [7:0] ADDR_RES  = 8'h10;
  localparam logic [3:0] LAST_OP   = 4'd8;
  localparam logic [3:0] LAST_RES  = 4'd4;

  state_t      state_r;
  logic [3:0]  idx_r;
  logic [31:0] op_r  [0:8];
  logic [31:0] res_r [0:4];
  logic        busy_r;
  logic        done_r;
  logic [7:0]  avm_address_r;
  logic        avm_read_r;
  logic        avm_write_r;
  logic [31:0] avm_writedata_r;

  logic        load_en_s;
  logic [31:0] first_word_s;
  logic [3:0]  next_idx_s;

  assign load_en_s    = ld_we && (state_r == S_IDLE) && (ld_addr <= LAST_OP);
  // A load of word 0 in the start cycle must reach the bus even though op_r updates on the same edge.
  assign first_word_s = (load_en_s && (ld_addr == 4'd0)) ? ld_data : op_r[0];
  assign next_idx_s   = idx_r + 4'd1;

`ifdef CORR_MASTER_TIMEOUT_EN
  localparam int unsigned PCW = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);
  logic [PCW-1:0] poll_cnt_r;
  logic           err_r;
  assign err = err_r;
`else
  // No timeout logic in this build: err is tied low, POLL_LIMIT kept only for a uniform parameter list.
  assign err = 1'b0 && (POLL_LIMIT != 32'd0);
`endif

  assign busy          = busy_r;
  assign done          = done_r;
  assign avm_address   = avm_address_r;
  assign avm_read      = avm_read_r;
  assign avm_write     = avm_write_r;
  assign avm_writedata = avm_writedata_r;

  // Operand register file, host-writable only while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) op_r[i] <= 32'd0;
    end else if (load_en_s) begin
      op_r[ld_addr] <= ld_data;
    end
  end

  // Sequencer: issues bus transfers, holds them through waitrequest and captures results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= S_IDLE;
      idx_r           <= 4'd0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      avm_address_r   <= 8'h00;
      avm_read_r      <= 1'b0;
      avm_write_r     <= 1'b0;
      avm_writedata_r <= 32'd0;
      for (int i = 0; i < 5; i++) res_r[i] <= 32'd0;
`ifdef CORR_MASTER_TIMEOUT_EN
      poll_cnt_r      <= {PCW{1'b0}};
      err_r           <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r         <= S_WR_DATA;
            busy_r          <= 1'b1;
            idx_r           <= 4'd0;
            avm_write_r     <= 1'b1;
            avm_read_r      <= 1'b0;
            avm_address_r   <= 8'h00;
            avm_writedata_r <= first_word_s;
`ifdef CORR_MASTER_TIMEOUT_EN
            poll_cnt_r      <= {PCW{1'b0}};
            err_r           <= 1'b0;
`endif
          end
        end
        S_WR_DATA: begin
          if (!avm_waitrequest) begin
            if (idx_r == LAST_OP) begin
              state_r         <= S_WR_SYNC1;
              avm_address_r   <= ADDR_SYNC;
              avm_writedata_r <= 32'h0000_0001;
            end else begin
              idx_r           <= next_idx_s;
              avm_address_r   <= {4'h0, next_idx_s};
              avm_writedata_r <= op_r[next_idx_s];
            end
          end
        end
        S_WR_SYNC1: begin
          if (!avm_waitrequest) begin
            state_r         <= S_POLL;
            avm_write_r     <= 1'b0;
            avm_read_r      <= 1'b1;
            avm_address_r   <= ADDR_ACK;
            avm_writedata_r <= 32'd0;
          end
        end
        S_POLL: begin
          // A nack leaves the read asserted, so the poll is re-issued on the next cycle.
          if (!avm_waitrequest) begin
            if (avm_readdata[0]) begin
              state_r       <= S_RD_RES;
              idx_r         <= 4'd0;
              avm_address_r <= ADDR_RES;
            end else begin
`ifdef CORR_MASTER_TIMEOUT_EN
              if (poll_cnt_r == POLL_LAST) begin
                err_r           <= 1'b1;
                state_r         <= S_WR_SYNC0;
                avm_read_r      <= 1'b0;
                avm_write_r     <= 1'b1;
                avm_address_r   <= ADDR_SYNC;
                avm_writedata_r <= 32'd0;
              end else begin
                poll_cnt_r <= poll_cnt_r + PCW'(1);
              end
`endif
            end
          end
        end
        S_RD_RES: begin
          if (!avm_waitrequest) begin
            res_r[idx_r[2:0]] <= avm_readdata;
            if (idx_r == LAST_RES) begin
              state_r         <= S_WR_SYNC0;
              avm_read_r      <= 1'b0;
              avm_write_r     <= 1'b1;
              avm_address_r   <= ADDR_SYNC;
              avm_writedata_r <= 32'd0;
            end else begin
              idx_r         <= next_idx_s;
              avm_address_r <= ADDR_RES + {4'h0, next_idx_s};
            end
          end
        end
        S_WR_SYNC0: begin
          if (!avm_waitrequest) begin
            state_r       <= S_DONE;
            avm_write_r   <= 1'b0;
            avm_address_r <= 8'h00;
            done_r        <= 1'b1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= S_IDLE;
          busy_r      <= 1'b0;
          avm_read_r  <= 1'b0;
          avm_write_r <= 1'b0;
        end
      endcase
    end
  end

  // Result read-back mux; unused selects read as zero.
  always_comb begin
    res_data = 32'd0;
    case (res_sel)
      3'd0:    res_data = res_r[0];
      3'd1:    res_data = res_r[1];
      3'd2:    res_data = res_r[2];
      3'd3:    res_data = res_r[3];
      3'd4:    res_data = res_r[4];
      default: res_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_corr_master.sv
// Directed bench for corr_master with a behavioural correlator slave on the Avalon-MM port.
// Define CORR_MASTER_TIMEOUT_EN for both files to include the poll-timeout scenario.
module tb_corr_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_we;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  res_sel;
  logic [31:0] res_data;
  logic [7:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_waitrequest = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Slave model state and bus monitor counters (written only by the slave process).
  logic [31:0] smem [0:8];
  int          sres [0:4];
  int          poll_n = 0, st_w = 0, st_r = 0;
  int          poll_tot = 0, res_tot = 0, wr_tot = 0, done_tot = 0;
  int          both_viol = 0, stab_cmp = 0, stab_viol = 0, stall_tot = 0;
  logic [7:0]  wr_a [0:255];
  logic [31:0] wr_d [0:255];
  logic        stalled_prev = 1'b0;
  logic [41:0] saved = 42'd0;
  logic        stall_s;

  // Scenario controls (written only by the stimulus process).
  int          ack_at = 2;
  logic        stall_mode = 1'b0;
  logic [31:0] ramp [0:4];

  corr_master #(.POLL_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done), .err(err), .res_sel(res_sel), .res_data(res_data),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign stall_s = stall_mode && ((avm_write && avm_address == 8'h04 && st_w < 3) ||
                                  (avm_read && avm_address == 8'h12 && st_r < 3));

  function automatic int corr(input int k);
    int acc;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      logic signed [7:0] t;
      logic signed [7:0] s;
      t = smem[i / 4][8 * (i % 4) +: 8];
      s = smem[4 + (i + k) / 4][8 * ((i + k) % 4) +: 8];
      acc += int'(t) * int'(s);
    end
    return acc;
  endfunction

  // Slave: decides waitrequest/readdata for the coming edge and retires the transfer that edge completes.
  always @(negedge clk) begin
    if (done) done_tot <= done_tot + 1;
    if (avm_read && avm_write) both_viol <= both_viol + 1;
    if (stalled_prev) begin
      stab_cmp <= stab_cmp + 1;
      if ({avm_address, avm_writedata, avm_read, avm_write} !== saved) stab_viol <= stab_viol + 1;
    end
    avm_waitrequest <= stall_s;
    stalled_prev    <= stall_s;
    saved           <= {avm_address, avm_writedata, avm_read, avm_write};
    if (stall_s) stall_tot <= stall_tot + 1;
    if (avm_address == 8'h0B) avm_readdata <= {31'd0, (ack_at != 0) && (poll_n + 1 == ack_at)};
    else if (avm_address >= 8'h10 && avm_address <= 8'h14) avm_readdata <= 32'(sres[avm_address - 8'h10]);
    else avm_readdata <= 32'd0;
    if (!avm_read && !avm_write) begin
      st_w <= 0; st_r <= 0; poll_n <= 0;
    end else if (stall_s) begin
      if (avm_write) st_w <= st_w + 1;
      else st_r <= st_r + 1;
    end else if (avm_write) begin
      wr_a[wr_tot] <= avm_address;
      wr_d[wr_tot] <= avm_writedata;
      wr_tot <= wr_tot + 1;
      if (avm_address <= 8'h08) smem[avm_address[3:0]] <= avm_writedata;
      if (avm_address == 8'h0A && avm_writedata == 32'd1)
        for (int k = 0; k < 5; k++) sres[k] <= corr(k);
    end else begin
      if (avm_address == 8'h0B) begin
        poll_tot <= poll_tot + 1;
        poll_n <= poll_n + 1;
      end
      if (avm_address >= 8'h10 && avm_address <= 8'h14) res_tot <= res_tot + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic load_ramp(input logic [31:0] tword);
    for (int a = 0; a < 4; a++) load(4'(a), tword);
    for (int w = 0; w < 5; w++) load(4'(w + 4), ramp[w]);
  endtask

  task automatic chk_res(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e4);
    logic [31:0] e [0:4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    for (int k = 0; k < 5; k++) begin
      res_sel = 3'(k);
      #1;
      chk($sformatf("%s_res%0d", tag, k), res_data, e[k]);
    end
    @(negedge clk);
  endtask

  // Starts a run at a falling edge and waits (bounded) for done; returns aligned to a falling edge.
  task automatic run(input logic [31:0] exp_w0, input int exp_lat, input bit poke, input string tag);
    int t0, n;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0; ld_we = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_first_xfer"}, {22'd0, avm_write, avm_read, avm_address}, {22'd0, 1'b1, 1'b0, 8'h00});
    chk({tag, "_first_data"}, avm_writedata, exp_w0);
    n = 1;
    while (done !== 1'b1 && n < 400) begin
      if (poke && n == 2) begin
        start = 1'b1; ld_we = 1'b1; ld_addr = 4'd0; ld_data = 32'h7F7F7F7F;
      end else begin
        start = 1'b0; ld_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; ld_we = 1'b0;
    chk({tag, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
    @(negedge clk);
    chk({tag, "_after_done"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int wb, pb, rb, sb, cb, db, n;
    ramp[0] = 32'h04030201; ramp[1] = 32'h08070605; ramp[2] = 32'h0C0B0A09;
    ramp[3] = 32'h100F0E0D; ramp[4] = 32'h14131211;
    reset_n = 1'b0; ld_we = 1'b0; ld_addr = 4'd0; ld_data = 32'd0; start = 1'b0; res_sel = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {29'd0, busy, done, err}, 32'd0);
    chk("rst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    chk("rst_addr", {24'd0, avm_address}, 32'd0);
    chk("rst_wdata", avm_writedata, 32'd0);
    chk("rst_res", res_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic run: template all ones, signal ramp 1..20.
    load_ramp(32'h01010101);
    wb = wr_tot; pb = poll_tot; rb = res_tot;
    run(32'h01010101, 19, 1'b0, "basic");
    chk("basic_wr_count", 32'(wr_tot - wb), 32'd11);
    for (int i = 0; i < 9; i++) chk($sformatf("basic_wr_addr%0d", i), {24'd0, wr_a[wb + i]}, 32'(i));
    chk("basic_wr_sig0", wr_d[wb + 4], 32'h04030201);
    chk("basic_wr_sig4", wr_d[wb + 8], 32'h14131211);
    chk("basic_sync1", {wr_a[wb + 9], wr_d[wb + 9][23:0]}, {8'h0A, 24'd1});
    chk("basic_sync0", {wr_a[wb + 10], wr_d[wb + 10][23:0]}, {8'h0A, 24'd0});
    chk("basic_polls", 32'(poll_tot - pb), 32'd2);
    chk("basic_res_reads", 32'(res_tot - rb), 32'd5);
    chk("basic_err", {31'd0, err}, 32'd0);
    chk_res("basic", 32'd136, 32'd152, 32'd168, 32'd184, 32'd200);
    res_sel = 3'd5; #1; chk("sel5_zero", res_data, 32'd0);
    res_sel = 3'd7; #1; chk("sel7_zero", res_data, 32'd0);
    @(negedge clk);

    // Waitrequest stalls on write 4 and read 0x12.
    stall_mode = 1'b1; sb = stall_tot; cb = stab_cmp;
    run(32'h01010101, 25, 1'b0, "stall");
    stall_mode = 1'b0;
    chk("stall_cycles", 32'(stall_tot - sb), 32'd6);
    chk("stall_compares", 32'(stab_cmp - cb), 32'd6);
    chk("stall_stable", 32'(stab_viol), 32'd0);
    chk_res("stall", 32'd136, 32'd152, 32'd168, 32'd184, 32'd200);

    // Word 0 loaded in the same cycle as start.
    ld_we = 1'b1; ld_addr = 4'd0; ld_data = 32'h02020202;
    run(32'h02020202, 19, 1'b0, "ldstart");
    chk_res("ldstart", 32'd146, 32'd166, 32'd186, 32'd206, 32'd226);

    // Start and load pulsed while busy are ignored.
    load(4'd0, 32'h01010101);
    db = done_tot;
    run(32'h01010101, 19, 1'b1, "poke");
    repeat (4) @(negedge clk);
    chk("poke_one_done", 32'(done_tot - db), 32'd1);
    chk("poke_idle", {31'd0, busy}, 32'd0);
    chk_res("poke", 32'd136, 32'd152, 32'd168, 32'd184, 32'd200);
    run(32'h01010101, 19, 1'b0, "poke_rerun");
    chk_res("poke_rerun", 32'd136, 32'd152, 32'd168, 32'd184, 32'd200);

`ifdef CORR_MASTER_TIMEOUT_EN
    // Ack never returned: four polls, then sync0 and err.
    ack_at = 0; wb = wr_tot; pb = poll_tot; rb = res_tot;
    run(32'h01010101, 16, 1'b0, "timeout");
    chk("timeout_err", {31'd0, err}, 32'd1);
    chk("timeout_polls", 32'(poll_tot - pb), 32'd4);
    chk("timeout_res_reads", 32'(res_tot - rb), 32'd0);
    chk("timeout_wr_count", 32'(wr_tot - wb), 32'd11);
    chk("timeout_sync0", {wr_a[wb + 10], wr_d[wb + 10][23:0]}, {8'h0A, 24'd0});
    chk_res("timeout_keep", 32'd136, 32'd152, 32'd168, 32'd184, 32'd200);
    ack_at = 2;
    run(32'h01010101, 19, 1'b0, "after_timeout");
    chk("err_cleared", {31'd0, err}, 32'd0);
`endif

    // Most negative bytes: signed products, 32-bit accumulation.
    for (int a = 0; a < 9; a++) load(4'(a), 32'h80808080);
    run(32'h80808080, 19, 1'b0, "neg");
    chk_res("neg", 32'd262144, 32'd262144, 32'd262144, 32'd262144, 32'd262144);

    // Reset dropped while reading results.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(avm_read === 1'b1 && avm_address === 8'h12) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_rd_res", {24'd0, avm_address}, 32'h12);
    reset_n = 1'b0;
    res_sel = 3'd0;
    #1;
    chk("midrst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_addr", {24'd0, avm_address}, 32'd0);
    chk("midrst_res0", res_data, 32'd0);
    res_sel = 3'd4; #1;
    chk("midrst_res4", res_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run(32'd0, 19, 1'b0, "post_rst_zero");
    chk_res("post_rst_zero", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    load_ramp(32'h01010101);
    run(32'h01010101, 19, 1'b0, "post_rst");
    chk_res("post_rst", 32'd136, 32'd152, 32'd168, 32'd184, 32'd200);
    chk("err_low", {31'd0, err}, 32'd0);
    chk("never_rd_and_wr", 32'(both_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
